// File: rtl/uart_cmd_responder.sv
// Byte-command responder for the host debug/load link.
// Decodes 'W' addr_hi addr_lo data / 'R' addr_hi addr_lo frames arriving on
// the receive stream, performs one wait-stated local bus access per frame and
// returns a single response byte ('K', the read byte, or '?' for an unknown
// opcode). A partial frame that stalls for TIMEOUT_CYCLES is dropped silently.
module uart_cmd_responder #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wdata,
    output logic                  bus_we,
    output logic                  bus_re,
    input  logic [7:0]            bus_rdata,
    input  logic                  bus_ack,
    output logic                  busy,
    output logic                  timeout
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_DATA    = 3'd3,
        ST_BUS     = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    // Counter wide enough to hold TIMEOUT_CYCLES-1; terminal count is the
    // last stalled cycle, so the drop happens exactly TIMEOUT_CYCLES cycles
    // after the most recent accepted byte.
    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit            TMO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t          state_r;
    state_t          next_state_s;
    logic            is_write_r;
    logic [7:0]      addr_hi_r;
    logic [CW-1:0]   tmo_cnt_r;

    logic                  s_axis_tready_r;
    logic [7:0]            m_axis_tdata_r;
    logic                  m_axis_tvalid_r;
    logic [ADDR_WIDTH-1:0] bus_addr_r;
    logic [7:0]            bus_wdata_r;
    logic                  bus_we_r;
    logic                  bus_re_r;
    logic                  busy_r;
    logic                  timeout_r;

    logic            in_hs_s;
    logic            out_hs_s;
    logic            in_frame_s;
    logic            tmo_term_s;
    logic            tmo_fire_s;
    logic [15:0]     addr_full_s;

    assign in_hs_s     = s_axis_tvalid && s_axis_tready_r;
    assign out_hs_s    = m_axis_tvalid_r && m_axis_tready;
    assign in_frame_s  = (state_r == ST_ADDR_HI) || (state_r == ST_ADDR_LO) || (state_r == ST_DATA);
    assign tmo_term_s  = TMO_EN && (tmo_cnt_r == TMO_LAST);
    assign addr_full_s = {addr_hi_r, s_axis_tdata};

    // Next-state decode; an accepted byte always takes priority over timeout
    always_comb begin
        next_state_s = state_r;
        tmo_fire_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_hs_s) begin
                    if ((s_axis_tdata == OP_WRITE) || (s_axis_tdata == OP_READ)) begin
                        next_state_s = ST_ADDR_HI;
                    end else begin
                        next_state_s = ST_RESP;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ADDR_HI, ST_ADDR_LO, ST_DATA: begin
                if (in_hs_s) begin
                    if (state_r == ST_ADDR_HI) begin
                        next_state_s = ST_ADDR_LO;
                    end else if ((state_r == ST_ADDR_LO) && is_write_r) begin
                        next_state_s = ST_DATA;
                    end else begin
                        next_state_s = ST_BUS;
                    end
                end else if (tmo_term_s) begin
                    next_state_s = ST_IDLE;
                    tmo_fire_s   = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_BUS: begin
                if (bus_ack) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_BUS;
                end
            end
            ST_RESP: begin
                if (out_hs_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus opcode and address-high capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            is_write_r <= 1'b0;
            addr_hi_r  <= 8'h00;
        end else begin
            state_r <= next_state_s;
            if ((state_r == ST_IDLE) && in_hs_s) begin
                is_write_r <= (s_axis_tdata == OP_WRITE);
            end else begin
                is_write_r <= is_write_r;
            end
            if ((state_r == ST_ADDR_HI) && in_hs_s) begin
                addr_hi_r <= s_axis_tdata;
            end else begin
                addr_hi_r <= addr_hi_r;
            end
        end
    end

    // Inter-byte timeout counter: runs only while stalled inside a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= '0;
        end else if (TMO_EN && in_frame_s && !in_hs_s && !tmo_fire_s) begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // Output registers, derived from the next state so they switch with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axis_tready_r <= 1'b0;
            m_axis_tdata_r  <= 8'h00;
            m_axis_tvalid_r <= 1'b0;
            bus_addr_r      <= '0;
            bus_wdata_r     <= 8'h00;
            bus_we_r        <= 1'b0;
            bus_re_r        <= 1'b0;
            busy_r          <= 1'b0;
            timeout_r       <= 1'b0;
        end else begin
            s_axis_tready_r <= (next_state_s == ST_IDLE) || (next_state_s == ST_ADDR_HI) ||
                               (next_state_s == ST_ADDR_LO) || (next_state_s == ST_DATA);
            m_axis_tvalid_r <= (next_state_s == ST_RESP);
            bus_we_r        <= (next_state_s == ST_BUS) && is_write_r;
            bus_re_r        <= (next_state_s == ST_BUS) && !is_write_r;
            busy_r          <= (next_state_s != ST_IDLE);
            timeout_r       <= tmo_fire_s;
            if ((state_r == ST_IDLE) && (next_state_s == ST_RESP)) begin
                m_axis_tdata_r <= RSP_ERR;
            end else if ((state_r == ST_BUS) && bus_ack) begin
                m_axis_tdata_r <= is_write_r ? RSP_OK : bus_rdata;
            end else begin
                m_axis_tdata_r <= m_axis_tdata_r;
            end
            if ((state_r == ST_ADDR_LO) && in_hs_s) begin
                bus_addr_r <= ADDR_WIDTH'(addr_full_s);
            end else begin
                bus_addr_r <= bus_addr_r;
            end
            if ((state_r == ST_DATA) && in_hs_s) begin
                bus_wdata_r <= s_axis_tdata;
            end else begin
                bus_wdata_r <= bus_wdata_r;
            end
        end
    end

    assign s_axis_tready = s_axis_tready_r;
    assign m_axis_tdata  = m_axis_tdata_r;
    assign m_axis_tvalid = m_axis_tvalid_r;
    assign bus_addr      = bus_addr_r;
    assign bus_wdata     = bus_wdata_r;
    assign bus_we        = bus_we_r;
    assign bus_re        = bus_re_r;
    assign busy          = busy_r;
    assign timeout       = timeout_r;

endmodule
